// File: rtl/l2_port_arbiter.sv
// Muxes IL1 and DL1 requests onto the single L2 port: data side first, instruction side forced after STARVE_MAX D wins.
// Latency: 1 cycle to grant + L2 latency + 1 response cycle. Optional counters under L2ARB_PERF_EN (otherwise perf_* = 0).
module l2_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_dout,
    output logic              i_ready,
    input  logic              d_en,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_din,
    output logic [DATA_W-1:0] d_dout,
    output logic              d_ready,
    output logic              l2_en,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_din,
    input  logic [DATA_W-1:0] l2_dout,
    input  logic              l2_ready,
    output logic              grant_d,
    output logic              busy,
    output logic [31:0]       perf_i,
    output logic [31:0]       perf_d,
    output logic [31:0]       perf_wait
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q;
    logic              l2_en_q, l2_we_q, i_ready_q, d_ready_q, owner_d_q, busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q, i_dout_q, d_dout_q;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              gnt_d, gnt_i;

    // Age counter only moves in IDLE, where grants are decided.
    always_comb begin
        gnt_d    = (state_q == IDLE) && d_en && (!i_en || (starve_q < STARVE_LIM));
        gnt_i    = (state_q == IDLE) && i_en && !gnt_d;
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (gnt_i || !i_en) begin
                starve_d = '0;
            end else if (gnt_d && (starve_q < STARVE_LIM)) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            l2_en_q   <= 1'b0;
            l2_we_q   <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            owner_d_q <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            i_dout_q  <= '0;
            d_dout_q  <= '0;
            starve_q  <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (gnt_d || gnt_i) begin
                        state_q   <= BUSY;
                        l2_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        owner_d_q <= gnt_d;
                        l2_we_q   <= gnt_d & d_we;
                        addr_q    <= gnt_d ? d_addr : i_addr;
                        din_q     <= gnt_d ? d_din : '0;
                    end
                end
                BUSY: begin
                    if (l2_ready) begin
                        state_q   <= RESP;
                        l2_en_q   <= 1'b0;
                        l2_we_q   <= 1'b0;
                        i_ready_q <= !owner_d_q;
                        d_ready_q <= owner_d_q;
                        if (owner_d_q) d_dout_q <= l2_dout;
                        else           i_dout_q <= l2_dout;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                    i_dout_q  <= '0;
                    d_dout_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign l2_en   = l2_en_q;
    assign l2_we   = l2_we_q;
    assign l2_addr = addr_q;
    assign l2_din  = din_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign i_dout  = i_dout_q;
    assign d_dout  = d_dout_q;
    assign grant_d = owner_d_q;
    assign busy    = busy_q;

`ifdef L2ARB_PERF_EN
    logic [31:0] perf_i_q, perf_d_q, perf_wait_q;
    logic        i_wait, d_wait;

    // A requester waits when it asks but neither owns the port nor is being granted now.
    always_comb begin
        i_wait = i_en && ((state_q == IDLE) ? !gnt_i : owner_d_q);
        d_wait = d_en && ((state_q == IDLE) ? !gnt_d : !owner_d_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_i_q    <= perf_i_q + 32'(gnt_i);
            perf_d_q    <= perf_d_q + 32'(gnt_d);
            perf_wait_q <= perf_wait_q + 32'(i_wait || d_wait);
        end
    end

    assign perf_i    = perf_i_q;
    assign perf_d    = perf_d_q;
    assign perf_wait = perf_wait_q;
`else
    assign perf_i    = '0;
    assign perf_d    = '0;
    assign perf_wait = '0;
`endif
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: cycle vector table plus starvation, reset and perf-counter sequences.
module tb_l2_port_arbiter;
    logic        clk = 1'b0;
    logic        reset, i_en, d_en, d_we, l2_ready;
    logic [31:0] i_addr, d_addr;
    logic [63:0] d_din, l2_dout;
    logic [63:0] i_dout, d_dout, l2_din;
    logic        i_ready, d_ready, l2_en, l2_we, grant_d, busy;
    logic [31:0] l2_addr, perf_i, perf_d, perf_wait;

    int errors = 0;
    int checks = 0;

    l2_port_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_en(i_en), .i_addr(i_addr), .i_dout(i_dout), .i_ready(i_ready),
        .d_en(d_en), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
        .d_dout(d_dout), .d_ready(d_ready),
        .l2_en(l2_en), .l2_we(l2_we), .l2_addr(l2_addr), .l2_din(l2_din),
        .l2_dout(l2_dout), .l2_ready(l2_ready),
        .grant_d(grant_d), .busy(busy),
        .perf_i(perf_i), .perf_d(perf_d), .perf_wait(perf_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, ien, den, dwe, l2rdy;
        logic [31:0] iaddr, daddr;
        logic [63:0] ddin, l2dout;
        bit          x_l2en, x_we, x_irdy, x_drdy, x_gd, x_busy;
        logic [31:0] x_addr;
        logic [63:0] x_din, x_idout, x_ddout;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input bit rst, input bit ien, input logic [31:0] iaddr,
                       input bit den, input bit dwe, input logic [31:0] daddr,
                       input logic [63:0] ddin, input logic [63:0] l2dout, input bit l2rdy,
                       input bit x_l2en, input bit x_we, input logic [31:0] x_addr,
                       input logic [63:0] x_din, input bit x_irdy, input logic [63:0] x_idout,
                       input bit x_drdy, input logic [63:0] x_ddout, input bit x_gd, input bit x_busy);
        vec_t v;
        v.rst = rst; v.ien = ien; v.iaddr = iaddr; v.den = den; v.dwe = dwe;
        v.daddr = daddr; v.ddin = ddin; v.l2dout = l2dout; v.l2rdy = l2rdy;
        v.x_l2en = x_l2en; v.x_we = x_we; v.x_addr = x_addr; v.x_din = x_din;
        v.x_irdy = x_irdy; v.x_idout = x_idout; v.x_drdy = x_drdy; v.x_ddout = x_ddout;
        v.x_gd = x_gd; v.x_busy = x_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_en = 1'b0; d_en = 1'b0; l2_ready = 1'b0; l2_dout = '0;
        step();
        reset = 1'b0;
    endtask

    // One transaction with the L2 answering in the first BUSY cycle.
    task automatic xact(input string nm, input bit exp_d, input bit drop,
                        input logic [63:0] rdata, input bit ck_starve);
        int k = 0;
        step();
        while (l2_en !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk({nm, "_l2en"}, {63'd0, l2_en}, 64'd1);
        chk({nm, "_grant"}, {63'd0, grant_d}, {63'd0, exp_d});
        if (ck_starve) chk({nm, "_starve"}, 64'(dut.starve_q), 64'd0);
        l2_ready = 1'b1; l2_dout = rdata;
        step();
        l2_ready = 1'b0; l2_dout = '0;
        chk({nm, "_own_rdy"}, {63'd0, exp_d ? d_ready : i_ready}, 64'd1);
        chk({nm, "_other_rdy"}, {63'd0, exp_d ? i_ready : d_ready}, 64'd0);
        chk({nm, "_resp_l2en"}, {63'd0, l2_en}, 64'd0);
        if (!exp_d) chk({nm, "_idout"}, i_dout, rdata);
        else if (!d_we) chk({nm, "_ddout"}, d_dout, rdata);
        step();
        chk({nm, "_idle_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_idle_rdy"}, {62'd0, i_ready, d_ready}, 64'd0);
        if (drop) begin
            if (exp_d) d_en = 1'b0;
            else       i_en = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b1; i_en = 1'b0; d_en = 1'b0; d_we = 1'b0; l2_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_din = '0; l2_dout = '0;
        step();
        step();
        chk("rst_perf_i", 64'(perf_i), 64'd0);
        chk("rst_perf_d", 64'(perf_d), 64'd0);
        chk("rst_perf_wait", 64'(perf_wait), 64'd0);
        chk("rst_douts", i_dout | d_dout, 64'd0);
        chk("rst_ctrl", {58'd0, l2_en, l2_we, i_ready, d_ready, busy, grant_d}, 64'd0);

        //   rst ien iaddr      den dwe daddr      ddin   l2dout   rdy | l2en we addr       din    irdy idout    drdy ddout    gd busy
        row(1, 0, 32'h0,    0, 0, 32'h0,    64'h0,  64'h0,    0,  0, 0, 32'h0,    64'h0,  0, 64'h0,    0, 64'h0,    0, 0);
        row(0, 1, 32'h100,  0, 0, 32'h0,    64'h0,  64'h0,    0,  1, 0, 32'h100,  64'h0,  0, 64'h0,    0, 64'h0,    0, 1);
        row(0, 1, 32'h100,  0, 0, 32'h0,    64'h0,  64'h0,    0,  1, 0, 32'h100,  64'h0,  0, 64'h0,    0, 64'h0,    0, 1);
        row(0, 1, 32'h100,  0, 0, 32'h0,    64'h0,  64'hABCD, 1,  0, 0, 32'h100,  64'h0,  1, 64'hABCD, 0, 64'h0,    0, 1);
        row(0, 1, 32'h100,  0, 0, 32'h0,    64'h0,  64'h0,    0,  0, 0, 32'h100,  64'h0,  0, 64'h0,    0, 64'h0,    0, 0);
        row(0, 0, 32'h0,    0, 0, 32'h0,    64'h0,  64'h0,    1,  0, 0, 32'h100,  64'h0,  0, 64'h0,    0, 64'h0,    0, 0);
        row(0, 0, 32'h0,    1, 1, 32'h2000, 64'h55, 64'h0,    0,  1, 1, 32'h2000, 64'h55, 0, 64'h0,    0, 64'h0,    1, 1);
        row(0, 0, 32'h0,    1, 1, 32'h2100, 64'h77, 64'h0,    0,  1, 1, 32'h2000, 64'h55, 0, 64'h0,    0, 64'h0,    1, 1);
        row(0, 0, 32'h0,    1, 1, 32'h2000, 64'h55, 64'hDEAD, 1,  0, 0, 32'h2000, 64'h0,  0, 64'h0,    1, 64'h0,    1, 1);
        row(0, 0, 32'h0,    1, 1, 32'h2000, 64'h55, 64'h0,    0,  0, 0, 32'h2000, 64'h0,  0, 64'h0,    0, 64'h0,    1, 0);
        row(0, 1, 32'h300,  1, 0, 32'h400,  64'h11, 64'h0,    0,  1, 0, 32'h400,  64'h0,  0, 64'h0,    0, 64'h0,    1, 1);
        row(0, 1, 32'h300,  1, 0, 32'h400,  64'h11, 64'h1234, 1,  0, 0, 32'h400,  64'h0,  0, 64'h0,    1, 64'h1234, 1, 1);
        row(0, 1, 32'h300,  1, 0, 32'h400,  64'h11, 64'h0,    0,  0, 0, 32'h400,  64'h0,  0, 64'h0,    0, 64'h0,    1, 0);
        row(0, 1, 32'h300,  0, 0, 32'h0,    64'h0,  64'h0,    0,  1, 0, 32'h300,  64'h0,  0, 64'h0,    0, 64'h0,    0, 1);
        row(0, 1, 32'h300,  0, 0, 32'h0,    64'h0,  64'h5678, 1,  0, 0, 32'h300,  64'h0,  1, 64'h5678, 0, 64'h0,    0, 1);
        row(0, 1, 32'h300,  0, 0, 32'h0,    64'h0,  64'h0,    0,  0, 0, 32'h300,  64'h0,  0, 64'h0,    0, 64'h0,    0, 0);
        row(0, 0, 32'h0,    0, 0, 32'h0,    64'h0,  64'h0,    0,  0, 0, 32'h300,  64'h0,  0, 64'h0,    0, 64'h0,    0, 0);
        row(0, 0, 32'h0,    1, 0, 32'h500,  64'h0,  64'h0,    0,  1, 0, 32'h500,  64'h0,  0, 64'h0,    0, 64'h0,    1, 1);
        row(1, 0, 32'h0,    1, 0, 32'h500,  64'h0,  64'h0,    0,  0, 0, 32'h0,    64'h0,  0, 64'h0,    0, 64'h0,    0, 0);
        row(0, 0, 32'h0,    0, 0, 32'h0,    64'h0,  64'h9,    1,  0, 0, 32'h0,    64'h0,  0, 64'h0,    0, 64'h0,    0, 0);
        row(0, 0, 32'h0,    0, 0, 32'h0,    64'h0,  64'h9,    1,  0, 0, 32'h0,    64'h0,  0, 64'h0,    0, 64'h0,    0, 0);

        foreach (vecs[n]) begin
            v = vecs[n];
            reset = v.rst; i_en = v.ien; i_addr = v.iaddr; d_en = v.den; d_we = v.dwe;
            d_addr = v.daddr; d_din = v.ddin; l2_dout = v.l2dout; l2_ready = v.l2rdy;
            step();
            chk($sformatf("v%0d_l2_en", n), {63'd0, l2_en}, {63'd0, v.x_l2en});
            chk($sformatf("v%0d_l2_we", n), {63'd0, l2_we}, {63'd0, v.x_we});
            chk($sformatf("v%0d_l2_addr", n), 64'(l2_addr), 64'(v.x_addr));
            if (v.x_we) chk($sformatf("v%0d_l2_din", n), l2_din, v.x_din);
            chk($sformatf("v%0d_i_ready", n), {63'd0, i_ready}, {63'd0, v.x_irdy});
            if (v.x_irdy) chk($sformatf("v%0d_i_dout", n), i_dout, v.x_idout);
            chk($sformatf("v%0d_d_ready", n), {63'd0, d_ready}, {63'd0, v.x_drdy});
            if (v.x_drdy && !v.dwe) chk($sformatf("v%0d_d_dout", n), d_dout, v.x_ddout);
            chk($sformatf("v%0d_grant_d", n), {63'd0, grant_d}, {63'd0, v.x_gd});
            chk($sformatf("v%0d_busy", n), {63'd0, busy}, {63'd0, v.x_busy});
        end

        // Instruction side held pending across back-to-back data reads: D,D,D,D,I,D.
        do_reset();
        i_en = 1'b1; i_addr = 32'h600; d_en = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_din = '0;
        xact("st0", 1'b1, 1'b0, 64'h10, 1'b0);
        xact("st1", 1'b1, 1'b0, 64'h11, 1'b0);
        xact("st2", 1'b1, 1'b0, 64'h12, 1'b0);
        xact("st3", 1'b1, 1'b0, 64'h13, 1'b0);
        xact("st4", 1'b0, 1'b1, 64'h14, 1'b1);
        xact("st5", 1'b1, 1'b1, 64'h15, 1'b0);

        // 3 I + 2 D, with I waiting behind the first D write for 3 cycles.
        do_reset();
        i_en = 1'b1; i_addr = 32'h800; d_en = 1'b1; d_we = 1'b1; d_addr = 32'h900; d_din = 64'h99;
        xact("pf0", 1'b1, 1'b1, 64'h0, 1'b0);
        xact("pf1", 1'b0, 1'b0, 64'h21, 1'b0);
        xact("pf2", 1'b0, 1'b0, 64'h22, 1'b0);
        xact("pf3", 1'b0, 1'b1, 64'h23, 1'b0);
        d_en = 1'b1;
        xact("pf4", 1'b1, 1'b1, 64'h0, 1'b0);
`ifdef L2ARB_PERF_EN
        chk("perf_i", 64'(perf_i), 64'd3);
        chk("perf_d", 64'(perf_d), 64'd2);
        chk("perf_wait", 64'(perf_wait), 64'd3);
`else
        chk("perf_i_off", 64'(perf_i), 64'd0);
        chk("perf_d_off", 64'(perf_d), 64'd0);
        chk("perf_wait_off", 64'(perf_wait), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
